// File: rtl/axby_pkg.sv
// Shared command/status layout for the axby datapath and its sequencer.
package axby_pkg;

  localparam int unsigned CMD_W = 8;
  localparam int unsigned ST_W  = 5;

  // Command word bit positions
  localparam int unsigned CMD_RESI  = 7;
  localparam int unsigned CMD_PLX   = 6;
  localparam int unsigned CMD_SHLX  = 5;
  localparam int unsigned CMD_PLY   = 4;
  localparam int unsigned CMD_SHLY  = 3;
  localparam int unsigned CMD_PLREZ = 2;
  localparam int unsigned CMD_INC   = 1;
  localparam int unsigned CMD_SEL   = 0;

  // Status vector bit positions
  localparam int unsigned ST_XZ = 4;
  localparam int unsigned ST_YZ = 3;
  localparam int unsigned ST_I2 = 2;
  localparam int unsigned ST_I6 = 1;
  localparam int unsigned ST_I7 = 0;

  localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/axby_shreg.sv
// Operand register: parallel load (wins) or shift left by one with zero fill.
module axby_shreg #(
  parameter int unsigned RW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          shift,
  input  logic [RW-1:0] din,
  output logic [RW-1:0] q
);

  // Load has priority over shift; otherwise hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {q[RW-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/axby_datapath.sv
// Datapath executing the sequencer command word on X, Y, REZ and step counter i.
module axby_datapath
  import axby_pkg::*;
#(
  parameter int unsigned W  = 8,
  parameter int unsigned RW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CMD_W-1:0]  cmd,
  input  logic              setrdyp,
  input  logic              start,
  input  logic [W-1:0]      xin,
  input  logic [W-1:0]      yin,
  output logic [ST_W-1:0]   status,
  output logic [RW-1:0]     rez,
  output logic              rdy
);

  logic [RW-1:0]    x_q;
  logic [RW-1:0]    y_q;
  logic [CNT_W-1:0] i_q;
  logic [RW-1:0]    rez_opnd;

  axby_shreg #(.RW(RW)) u_x (
    .clk   (clk),
    .rst   (rst),
    .load  (cmd[CMD_PLX]),
    .shift (cmd[CMD_SHLX]),
    .din   (RW'(xin)),
    .q     (x_q)
  );

  axby_shreg #(.RW(RW)) u_y (
    .clk   (clk),
    .rst   (rst),
    .load  (cmd[CMD_PLY]),
    .shift (cmd[CMD_SHLY]),
    .din   (RW'(yin)),
    .q     (y_q)
  );

  // Accumulator operand uses the pre-edge register value
  assign rez_opnd = cmd[CMD_SEL] ? y_q : x_q;

  // Result accumulator; resi clears and beats plrez
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rez <= '0;
    end else if (cmd[CMD_RESI]) begin
      rez <= '0;
    end else if (cmd[CMD_PLREZ]) begin
      rez <= rez + rez_opnd;
    end
  end

  // Step counter, wraps naturally at 3 bits; resi beats inc
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q <= '0;
    end else if (cmd[CMD_RESI]) begin
      i_q <= '0;
    end else if (cmd[CMD_INC]) begin
      i_q <= i_q + CNT_W'(1);
    end
  end

  // Ready flag: set pulse wins over start clearing it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy <= 1'b0;
    end else if (setrdyp) begin
      rdy <= 1'b1;
    end else if (start) begin
      rdy <= 1'b0;
    end
  end

  // Condition vector decoded straight from registers
  always_comb begin
    status        = '0;
    status[ST_XZ] = (x_q == '0);
    status[ST_YZ] = (y_q == '0);
    status[ST_I2] = (i_q == CNT_W'(2));
    status[ST_I6] = (i_q == CNT_W'(6));
    status[ST_I7] = (i_q == CNT_W'(7));
  end

endmodule
